// File: rtl/busy_free_arbiter_pkg.sv
// Shared definitions for the busytable free-port arbiter.
//   - physical register sizing (PREG_W, PREG_RANGE, PREG_SIZE)
//   - ROB state encodings used to gate grants
//   - writeback requester index constants
//   - one-hot to index helper used for the round-robin pointer update
package busy_free_arbiter_pkg;

  localparam int NUM_REQ    = 4;
  localparam int PTR_W      = 2;
  localparam int PREG_W     = 6;
  localparam int PREG_RANGE = PREG_W - 1;
  localparam int PREG_SIZE  = 64;

  localparam logic [1:0] ROB_STATE_IDLE          = 2'd0;
  localparam logic [1:0] ROB_STATE_WALKING       = 2'd1;
  localparam logic [1:0] ROB_STATE_OVERWRITE_RAT = 2'd2;

  localparam logic [PTR_W-1:0] WB_REQ_ALU0 = 2'd0;
  localparam logic [PTR_W-1:0] WB_REQ_ALU1 = 2'd1;
  localparam logic [PTR_W-1:0] WB_REQ_MDU  = 2'd2;
  localparam logic [PTR_W-1:0] WB_REQ_LSU  = 2'd3;

  function automatic logic [PTR_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/busy_free_arbiter_rr_pick2.sv
// Combinational two-wide round-robin picker.
//   valid  : request vector
//   ptr    : highest-priority index
//   g0_oh/g0_vld : first valid index scanning upward from ptr (mod NUM_REQ)
//   g1_oh/g1_vld : next valid index after g0, before wrapping back to ptr
module busy_free_arbiter_rr_pick2
  import busy_free_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] g0_oh,
  output logic               g0_vld,
  output logic [NUM_REQ-1:0] g1_oh,
  output logic               g1_vld
);

  logic [PTR_W-1:0] idx;

  // A single scan of all NUM_REQ offsets from ptr; the index arithmetic
  // wraps naturally in PTR_W bits, so g1 can never revisit ptr.
  always_comb begin
    g0_oh  = '0;
    g0_vld = 1'b0;
    g1_oh  = '0;
    g1_vld = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + PTR_W'(k);
      if (valid[idx]) begin
        if (!g0_vld) begin
          g0_oh[idx] = 1'b1;
          g0_vld     = 1'b1;
        end else if (!g1_vld) begin
          g1_oh[idx] = 1'b1;
          g1_vld     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/busy_free_arbiter.sv
// Shares the busytable's two free ports among the writeback requesters
// (ALU0, ALU1, MUL/DIV, LSU). Up to two grants per cycle, two-wide
// round-robin, all grants suppressed while the ROB overwrites the RAT.
//   clock, reset            : clock, synchronous active-high reset
//   req_valid/req_prd       : per-requester prd to free (prd i at [i*PREG_W +: PREG_W])
//   req_ready               : combinational accept per requester
//   rob_state               : ROB state (ROB_STATE_*)
//   free_en0/1, free_addr0/1: registered busytable free ports
//   grant_cnt               : grants accepted last cycle, registered
module busy_free_arbiter
  import busy_free_arbiter_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*PREG_W-1:0] req_prd,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [1:0]                rob_state,
  output logic                      free_en0,
  output logic [PREG_W-1:0]         free_addr0,
  output logic                      free_en1,
  output logic [PREG_W-1:0]         free_addr1,
  output logic [1:0]                grant_cnt
);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               free_en0_q, free_en0_d;
  logic               free_en1_q, free_en1_d;
  logic [PREG_W-1:0]  free_addr0_q, free_addr0_d;
  logic [PREG_W-1:0]  free_addr1_q, free_addr1_d;
  logic [1:0]         grant_cnt_q, grant_cnt_d;

  logic [NUM_REQ-1:0] g0_oh, g1_oh;
  logic               g0_vld, g1_vld;
  logic               gate, acc0, acc1;
  logic [PREG_W-1:0]  prd0, prd1;

  busy_free_arbiter_rr_pick2 u_pick (
    .valid  (req_valid),
    .ptr    (rr_ptr_q),
    .g0_oh  (g0_oh),
    .g0_vld (g0_vld),
    .g1_oh  (g1_oh),
    .g1_vld (g1_vld)
  );

  // Reset gates ready combinationally so a pending valid is not counted as
  // a transfer on the reset edge.
  assign gate = ~reset & (rob_state != ROB_STATE_OVERWRITE_RAT);
  assign acc0 = gate & g0_vld;
  assign acc1 = gate & g1_vld;

  assign req_ready = (g0_oh & {NUM_REQ{acc0}}) | (g1_oh & {NUM_REQ{acc1}});

  always_comb begin
    prd0 = '0;
    prd1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g0_oh[i]) prd0 = req_prd[i*PREG_W +: PREG_W];
      if (g1_oh[i]) prd1 = req_prd[i*PREG_W +: PREG_W];
    end
  end

  always_comb begin
    free_en0_d   = acc0;
    free_en1_d   = acc1;
    free_addr0_d = acc0 ? prd0 : free_addr0_q;
    free_addr1_d = acc1 ? prd1 : free_addr1_q;
    // acc1 implies acc0, so the count is {acc1, acc0 & ~acc1}.
    grant_cnt_d  = {acc1, acc0 & ~acc1};
    rr_ptr_d     = rr_ptr_q;
    if (acc1)      rr_ptr_d = oh2idx(g1_oh) + 2'd1;
    else if (acc0) rr_ptr_d = oh2idx(g0_oh) + 2'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      free_en0_q   <= 1'b0;
      free_en1_q   <= 1'b0;
      free_addr0_q <= '0;
      free_addr1_q <= '0;
      grant_cnt_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      free_en0_q   <= free_en0_d;
      free_en1_q   <= free_en1_d;
      free_addr0_q <= free_addr0_d;
      free_addr1_q <= free_addr1_d;
      grant_cnt_q  <= grant_cnt_d;
    end
  end

  assign free_en0   = free_en0_q;
  assign free_en1   = free_en1_q;
  assign free_addr0 = free_addr0_q;
  assign free_addr1 = free_addr1_q;
  assign grant_cnt  = grant_cnt_q;

endmodule

// File: tb/tb_busy_free_arbiter.sv
// Directed bench for busy_free_arbiter. Each step drives one cycle of
// requests, checks req_ready before the edge, and queues the registered
// outputs expected after the edge for the monitor process.
module tb_busy_free_arbiter;
  import busy_free_arbiter_pkg::*;

  typedef struct {
    logic       en0;
    logic [5:0] a0;
    logic       en1;
    logic [5:0] a1;
    logic [1:0] cnt;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [23:0] req_prd;
  logic [3:0]  req_ready;
  logic [1:0]  rob_state;
  logic        free_en0, free_en1;
  logic [5:0]  free_addr0, free_addr1;
  logic [1:0]  grant_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  busy_free_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_prd    (req_prd),
    .req_ready  (req_ready),
    .rob_state  (rob_state),
    .free_en0   (free_en0),
    .free_addr0 (free_addr0),
    .free_en1   (free_en1),
    .free_addr1 (free_addr1),
    .grant_cnt  (grant_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: registered outputs appear one edge after the step that queued them.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("free_en0",   {7'd0, free_en0},   {7'd0, e.en0});
        chk("free_addr0", {2'd0, free_addr0}, {2'd0, e.a0});
        chk("free_en1",   {7'd0, free_en1},   {7'd0, e.en1});
        chk("free_addr1", {2'd0, free_addr1}, {2'd0, e.a1});
        chk("grant_cnt",  {6'd0, grant_cnt},  {6'd0, e.cnt});
      end
    end
  end

  task automatic step(input logic rst, input logic [1:0] rob, input logic [3:0] v,
                      input logic [5:0] p3, input logic [5:0] p2,
                      input logic [5:0] p1, input logic [5:0] p0,
                      input logic [3:0] rdy,
                      input logic e0, input logic [5:0] a0,
                      input logic e1, input logic [5:0] a1, input logic [1:0] cnt);
    exp_t e;
    @(negedge clock);
    reset     = rst;
    rob_state = rob;
    req_valid = v;
    req_prd   = {p3, p2, p1, p0};
    #1;
    chk("req_ready", {4'd0, req_ready}, {4'd0, rdy});
    e.en0 = e0; e.a0 = a0; e.en1 = e1; e.a1 = a1; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rob_state = ROB_STATE_IDLE; req_valid = '0; req_prd = '0;
    //    rst  rob                      valid    p3     p2     p1     p0     ready    en0 a0    en1 a1    cnt
    step(1, ROB_STATE_IDLE,          4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b0000, 0, 6'h00, 0, 6'h00, 0);
    step(1, ROB_STATE_IDLE,          4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b0000, 0, 6'h00, 0, 6'h00, 0);
    // single request from req 2, ptr 0 -> ptr 3
    step(0, ROB_STATE_IDLE,          4'b0100, 6'h00, 6'h15, 6'h00, 6'h00, 4'b0100, 1, 6'h15, 0, 6'h00, 1);
    // wrap: ptr 3, req 3 and req 0 -> g0=3, g1=0, ptr 1
    step(0, ROB_STATE_IDLE,          4'b1001, 6'h31, 6'h00, 6'h00, 6'h30, 4'b1001, 1, 6'h31, 1, 6'h30, 2);
    // idle: enables drop, addresses hold
    step(0, ROB_STATE_IDLE,          4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b0000, 0, 6'h31, 0, 6'h30, 0);
    // ptr 1, req 3 only -> ptr 0
    step(0, ROB_STATE_IDLE,          4'b1000, 6'h0a, 6'h00, 6'h00, 6'h00, 4'b1000, 1, 6'h0a, 0, 6'h30, 1);
    // all four valid from ptr 0
    step(0, ROB_STATE_IDLE,          4'b1111, 6'h04, 6'h03, 6'h02, 6'h01, 4'b0011, 1, 6'h01, 1, 6'h02, 2);
    step(0, ROB_STATE_IDLE,          4'b1111, 6'h04, 6'h03, 6'h02, 6'h01, 4'b1100, 1, 6'h03, 1, 6'h04, 2);
    // flush for two cycles, ptr held at 0
    step(0, ROB_STATE_OVERWRITE_RAT, 4'b1111, 6'h04, 6'h03, 6'h02, 6'h01, 4'b0000, 0, 6'h03, 0, 6'h04, 0);
    step(0, ROB_STATE_OVERWRITE_RAT, 4'b1111, 6'h04, 6'h03, 6'h02, 6'h01, 4'b0000, 0, 6'h03, 0, 6'h04, 0);
    step(0, ROB_STATE_IDLE,          4'b1111, 6'h04, 6'h03, 6'h02, 6'h01, 4'b0011, 1, 6'h01, 1, 6'h02, 2);
    // walking allows grants; ptr 2, req 0 only -> ptr 1
    step(0, ROB_STATE_WALKING,       4'b0001, 6'h00, 6'h00, 6'h00, 6'h11, 4'b0001, 1, 6'h11, 0, 6'h02, 1);
    // duplicate prd; ptr 1 -> g0=1, g1=0, ptr 1
    step(0, ROB_STATE_IDLE,          4'b0011, 6'h00, 6'h00, 6'h20, 6'h20, 4'b0011, 1, 6'h20, 1, 6'h20, 2);
    // three valid from ptr 1 -> 1,2 granted, ptr 3; waiting req 0 next
    step(0, ROB_STATE_IDLE,          4'b0111, 6'h00, 6'h07, 6'h06, 6'h05, 4'b0110, 1, 6'h06, 1, 6'h07, 2);
    step(0, ROB_STATE_IDLE,          4'b0001, 6'h00, 6'h00, 6'h00, 6'h05, 4'b0001, 1, 6'h05, 0, 6'h07, 1);
    // reset mid-stream with req 1 pending (ptr was 1)
    step(1, ROB_STATE_IDLE,          4'b0010, 6'h00, 6'h00, 6'h2a, 6'h00, 4'b0000, 0, 6'h00, 0, 6'h00, 0);
    // ptr back at 0 -> g0=0, g1=1
    step(0, ROB_STATE_IDLE,          4'b0011, 6'h00, 6'h00, 6'h2a, 6'h2b, 4'b0011, 1, 6'h2b, 1, 6'h2a, 2);
    step(0, ROB_STATE_IDLE,          4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b0000, 0, 6'h2b, 0, 6'h2a, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/busy_free_arbiter.md
Name: busy_free_arbiter

Overview:
- Shares the busytable's two free (clear-busy) ports among NUM_REQ writeback requesters: ALU0, ALU1, MUL/DIV and LSU.
- Each requester presents a physical destination register (prd) with a valid/ready handshake.
- Grants at most two per cycle, using two-wide round-robin priority.
- Drives registered free_en0/1 and free_addr0/1 into the busytable.
- Suppresses all grants while the ROB is in its overwrite state.
- Sits in dispatch, between the execution writeback buses and the busytable.

Parameters:
- NUM_REQ, 4, number of writeback requesters. Fixed at 4 in this version; the pointer is 2 bits.
- PREG_W, 6, physical register index width. Matches PREG_RANGE and 64 pregs.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a prd to free
- req_prd  in  NUM_REQ*PREG_W  prd of requester i, packed at bits [i*PREG_W +: PREG_W]
- req_ready  out  NUM_REQ  requester i's prd is accepted this cycle
- rob_state  in  2  ROB state, encoded with ROB_STATE_* constants
- free_en0  out  1  busytable free port 0 enable
- free_addr0  out  PREG_W  busytable free port 0 address
- free_en1  out  1  busytable free port 1 enable
- free_addr1  out  PREG_W  busytable free port 1 address
- grant_cnt  out  2  number of grants accepted last cycle (0..2), registered, for perf counters

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - free_en0 = free_en1 = 0; free_addr0 = free_addr1 = 0.
  - grant_cnt = 0; rr_ptr = 0.
  - req_ready is forced to 0 while reset = 1.
- Handshake:
  - A transfer happens on requester i when req_valid[i] & req_ready[i] at a rising edge.
  - A requester holds req_valid and req_prd stable until accepted.
  - req_ready is combinational from req_valid, rr_ptr, reset and rob_state; it never depends on downstream state.
- Arbitration (combinational picker):
  - g0 = first i with req_valid[i], scanning from rr_ptr upward modulo NUM_REQ.
  - g1 = first valid i after g0, scanning modulo NUM_REQ and stopping before returning to rr_ptr. g1 is always distinct from g0.
  - req_ready is high only for g0 and g1, and only when they exist.
- Latency: exactly one cycle.
  - The accepted prd for g0 appears on free_en0/free_addr0 at the next edge.
  - The accepted prd for g1 appears on free_en1/free_addr1 at the next edge.
  - free_en1 is never 1 while free_en0 is 0.
  - When nothing is accepted, the enables drop to 0 and the addresses hold their previous values.
- Pointer update:
  - Two grants: rr_ptr <= (g1+1) mod NUM_REQ.
  - One grant: rr_ptr <= (g0+1) mod NUM_REQ.
  - No grants: rr_ptr is unchanged.
  - The pointer wraps 3 -> 0.
- Flush (rob_state == ROB_STATE_OVERWRITE_RAT):
  - req_ready is all 0, so nothing is accepted and rr_ptr holds.
  - free_en0/1 are 0 at the next edge.
  - Enables already registered in the flush cycle stay visible for that cycle only; the busytable clears itself in that state, so this is harmless.
  - ROB_STATE_WALKING and ROB_STATE_IDLE both allow grants normally.
- Duplicate prd: if two requesters present the same prd in one cycle, both are granted and both ports carry it. No dedup is performed.
- Reset mid-operation: a pending valid is not accepted. The registered outputs clear at the reset edge, and requesters resubmit after reset.
- No starvation: a requester that stays valid is granted within NUM_REQ/2 = 2 cycles of flush-free operation.

Decomposition:
- Shared package (defines.sv):
  - PREG_RANGE, PREG_SIZE.
  - ROB_STATE_IDLE, ROB_STATE_WALKING, ROB_STATE_OVERWRITE_RAT.
  - New WB_REQ_ALU0/ALU1/MDU/LSU index constants.
- One sub-module, rr_pick2: combinational two-wide round-robin picker.
  - Inputs: valid vector, pointer.
  - Outputs: g0/g1 one-hot plus valid bits.
- The top level holds rr_ptr, the output registers, the flush gating and grant_cnt.

Test Plan:
- Single request: rr_ptr=0, only req 2 valid with prd=0x15 -> req_ready=0100. Next cycle free_en0=1, free_addr0=0x15, free_en1=0, grant_cnt=1, rr_ptr=3.
- All four valid (prds 1,2,3,4), rr_ptr=0:
  - cycle 0 -> ready=0011; next cycle ports carry 1 and 2, rr_ptr=2.
  - cycle 1 -> ready=1100; next cycle ports carry 3 and 4, rr_ptr=0.
- Wrap: rr_ptr=3 with req 3 and req 0 valid -> g0=3, g1=0. free_addr0 carries req 3's prd and free_addr1 carries req 0's prd; rr_ptr=1.
- Flush: all valid with rob_state=OVERWRITE_RAT for 2 cycles -> req_ready=0000, free_en0/1=0 after the first edge, rr_ptr unchanged. On return to IDLE, grants resume from the same rr_ptr.
- Duplicate prd: req 0 and req 1 both prd=0x20 -> both ready; free_addr0 = free_addr1 = 0x20 with both enables set.
- Reset mid-stream: reset asserted while req 1 is valid -> req_ready=0000 during reset; after reset, outputs=0 and rr_ptr=0; req 1 is granted on the first cycle after reset deasserts.
